// File: rtl/apple1_pkg.sv
// Shared constants for the Apple-1 PIA block: register offsets within
// the $D010-$D013 window and the position of the status bit.
package apple1_pkg;

    localparam logic [1:0] PIA_KBD   = 2'd0;
    localparam logic [1:0] PIA_KBDCR = 2'd1;
    localparam logic [1:0] PIA_DSP   = 2'd2;
    localparam logic [1:0] PIA_DSPCR = 2'd3;

    localparam int STATUS_BIT = 7;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with the head entry always visible on head_data.
// DEPTH must be a power of two so the pointers wrap for free.
module sync_fifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    // Storage needs no reset: an entry is only ever read after being written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/apple1_pia.sv
// Apple-1 PIA: keyboard data/status backed by a receive FIFO and a display
// data/status pair with a valid/ready handshake toward the video side.
module apple1_pia
    import apple1_pkg::*;
#(
    parameter int KBD_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       cs,
    input  logic [1:0] address,
    input  logic       we,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic [6:0] kbd_data,
    input  logic       kbd_valid,
    output logic       kbd_ready,
    output logic [6:0] disp_data,
    output logic       disp_valid,
    input  logic       disp_ready
);

    logic       access;
    logic       cpu_write;
    logic       kbd_pop;
    logic       kbd_push;
    logic       kbd_full;
    logic       kbd_empty;
    logic [6:0] kbd_head;
    logic [6:0] last_popped;
    logic [6:0] kbdcr;
    logic [6:0] dspcr;
    logic [6:0] dsp;
    logic       busy;
    logic [7:0] read_data;
    logic       unused_din7;

    assign unused_din7 = din[7];

    assign access    = enable && cs;
    assign cpu_write = access && we;
    assign kbd_pop   = access && !we && (address == PIA_KBD) && !kbd_empty;
    assign kbd_push  = kbd_valid && !kbd_full;
    assign kbd_ready = !kbd_full;

    assign disp_valid = busy;
    assign disp_data  = dsp;

    sync_fifo #(
        .WIDTH (7),
        .DEPTH (KBD_DEPTH)
    ) u_kbd_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (kbd_push),
        .pop       (kbd_pop),
        .push_data (kbd_data),
        .head_data (kbd_head),
        .full      (kbd_full),
        .empty     (kbd_empty)
    );

    // An empty keyboard register keeps showing the last code the CPU consumed.
    always_comb begin
        read_data = 8'h00;
        case (address)
            PIA_KBD: begin
                read_data[STATUS_BIT] = 1'b1;
                read_data[6:0]        = kbd_empty ? last_popped : kbd_head;
            end
            PIA_KBDCR: begin
                read_data[STATUS_BIT] = !kbd_empty;
                read_data[6:0]        = kbdcr;
            end
            PIA_DSP: begin
                read_data[STATUS_BIT] = busy;
                read_data[6:0]        = dsp;
            end
            default: begin
                read_data[STATUS_BIT] = 1'b0;
                read_data[6:0]        = dspcr;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dout        <= 8'h00;
            last_popped <= '0;
        end else begin
            if (cs && !we) begin
                dout <= read_data;
            end
            if (kbd_pop) begin
                last_popped <= kbd_head;
            end
        end
    end

    // A CPU write to DSP outranks a display accept on the same clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            kbdcr <= '0;
            dspcr <= '0;
            dsp   <= '0;
            busy  <= 1'b0;
        end else begin
            if (cpu_write && (address == PIA_KBDCR)) begin
                kbdcr <= din[6:0];
            end
            if (cpu_write && (address == PIA_DSPCR)) begin
                dspcr <= din[6:0];
            end
            if (cpu_write && (address == PIA_DSP)) begin
                dsp  <= din[6:0];
                busy <= 1'b1;
            end else if (busy && disp_ready) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: doc/apple1_pia.md
# apple1_pia

Keyboard/display I/O block that decodes the CPU bus produced by the `enable`-gated 6502 wrapper and returns read data to its `dbi` input. It implements the Apple-1 PIA register map at $D010–$D013:
- a keyboard data/status pair backed by a small receive FIFO;
- a display data/status pair with a valid/ready handshake toward the video/UART side.

The top-level address decoder supplies `cs`.

## Interface
- `KBD_DEPTH`, 4: keyboard FIFO entries; power of two, ≥ 2.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: CPU clock enable; the same strobe that drives the 6502 wrapper.
- `cs` in 1: chip select, high when `ab[15:2]` decodes to $D01x block.
- `address` in 2: `ab[1:0]`; 0=KBD, 1=KBDCR, 2=DSP, 3=DSPCR.
- `we` in 1: CPU write strobe (registered by the wrapper).
- `din` in 8: CPU write data (wrapper `dbo`).
- `dout` out 8: CPU read data (to wrapper `dbi`), registered.
- `kbd_data` in 7: ASCII key code.
- `kbd_valid` in 1: key code offered.
- `kbd_ready` out 1: FIFO can accept; high when not full.
- `disp_data` out 7: character to display.
- `disp_valid` out 1: character pending; equals the display busy flag.
- `disp_ready` in 1: display sink accepts.

## Operation
- **Bus access:** a CPU access occurs on a clock with `enable`=1 and `cs`=1. Reads have `we`=0; writes have `we`=1. Side effects happen only on such clocks.
- **Keyboard push:** when `kbd_valid` and `kbd_ready` are both high, `kbd_data` is written to the FIFO tail.
- **KBD read (addr 0):**
  - `dout` = {1'b1, head}.
  - Pops the FIFO when it is non-empty.
  - When empty, returns {1'b1, last popped code} with no pop; this is 8'h80 after reset.
- **KBDCR read (addr 1):** `dout` = {!empty, kbdcr[6:0]}.
- **DSP read (addr 2):** `dout` = {busy, dsp[6:0]}.
- **DSPCR read (addr 3):** `dout` = {1'b0, dspcr[6:0]}.
- **Register writes:**
  - Addr 1: loads `kbdcr[6:0]` from `din[6:0]`.
  - Addr 3: loads `dspcr[6:0]` from `din[6:0]`.
  - Addr 0: ignored.
- **DSP write (addr 2):**
  - Loads `dsp[6:0]` from `din[6:0]` and sets `busy`=1.
  - A write while `busy` overwrites the pending character; `busy` stays 1.
- **Display handshake:**
  - `disp_valid` = `busy`; `disp_data` = `dsp[6:0]`.
  - A clock with `disp_valid` && `disp_ready` clears `busy`.
- **Simultaneous events:**
  - DSP write on the same clock as a display accept: the write wins, so `busy`=1 and the new data is pending.
  - FIFO push and pop on the same clock: both happen and the count is unchanged. When full, no push can occur because `kbd_ready`=0.
  - Push into an empty FIFO on the same clock as a KBD read: the read returns the old value and does not pop. The pushed entry is visible next clock.
- **Address wrap:** FIFO pointers wrap modulo `KBD_DEPTH`. The count is `log2(KBD_DEPTH)+1` bits wide.

## Timing
- **Read data:** `dout` is registered every `clk` from the current `address`/`cs`/`we`. It is valid one clock after `address` changes and is held stable while `address` holds. This satisfies the wrapper, whose registered `ab` stays constant between `enable` pulses.
- **Deselected:** when `cs`=0 or `we`=1, `dout` retains its previous value.
- **Status visibility:**
  - A push is visible in KBDCR bit 7 on the clock after the push edge.
  - `busy` rises on the clock after the DSP write edge.
  - `kbd_ready` falls on the clock after the FIFO becomes full.
- **Reset values:** FIFO empty, `kbd_ready`=1, `busy`=0, `disp_valid`=0, `disp_data`=0, `dout`=8'h00, `kbdcr`=`dspcr`=`dsp`=0, last-popped=0. Reset asserted mid-transfer discards FIFO contents and any pending character.

## Structure
- **Shared package `apple1_pkg`:**
  - Register offset constants `PIA_KBD`, `PIA_KBDCR`, `PIA_DSP`, `PIA_DSPCR`.
  - Bit-7 status index constant.
- **Sub-module `sync_fifo`:** parameterised width (7) and depth, with `clk`/`reset`, push/pop, `full`/`empty`, and head data out. The display side stays inline.

## Test plan
- **Reset:** assert `reset` 2 clocks -> `dout`=00, `kbd_ready`=1, `disp_valid`=0; KBDCR read -> 8'h00; KBD read -> 8'h80.
- **Key round-trip:** push 7'h41 -> KBDCR read 8'h80; KBD read 8'hC1; KBDCR read 8'h00.
- **FIFO full:**
  - Push 7'h31–7'h34 with `kbd_valid` held -> `kbd_ready`=0 after the 4th; a 5th code (7'h35) is dropped.
  - Four KBD reads -> B1, B2, B3, B4.
  - 5th read -> B4 with no pop.
- **Display handshake:**
  - Write DSP 8'hC1 with `disp_ready`=0 -> `disp_valid`=1, `disp_data`=41; DSP read -> 8'hC1.
  - Raise `disp_ready` one clock -> `disp_valid`=0; DSP read -> 8'h41.
- **DSP write and accept on the same clock:**
  - Setup: `busy` with 7'h41; write 8'h42 on the same clock as a 41 accept.
  - Required: `disp_valid` stays 1, `disp_data`=42.
- **Enable gating and mid-transfer reset:**
  - Hold KBD address with `enable`=0 for 10 clocks -> no pop.
  - Assert `reset` while `busy`=1 and the FIFO holds 2 entries -> all state returns to reset values.
